// File: rtl/rv_pipe_pkg.sv
// rtl/rv_pipe_pkg.sv - shared constants and types for the RISC-V pipeline stages
package rv_pipe_pkg;

  localparam int XLEN   = 32;
  localparam int RA_W   = 5;
  localparam int CTRL_W = 12;

  localparam logic [RA_W-1:0] REG_ZERO = 5'd0;

  // Bit offsets of the named fields inside the control bundle
  localparam int CTRL_ALU_OP_LSB = 0;
  localparam int CTRL_ALU_OP_W   = 4;
  localparam int CTRL_MEM_READ   = 4;
  localparam int CTRL_MEM_WRITE  = 5;
  localparam int CTRL_REG_WRITE  = 6;

  // Control bundle as carried down the pipe; spare bits are reserved for later stages
  typedef struct packed {
    logic [4:0]               spare;
    logic                     reg_write;
    logic                     mem_write;
    logic                     mem_read;
    logic [CTRL_ALU_OP_W-1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/fwd_mux.sv
// rtl/fwd_mux.sv - source operand select between x0, EX forward, WB forward and register file
module fwd_mux
  import rv_pipe_pkg::*;
(
  input  logic [RA_W-1:0] rs,
  input  logic [XLEN-1:0] rf_data,
  input  logic            ex_wen,
  input  logic            ex_is_load,
  input  logic [RA_W-1:0] ex_rd,
  input  logic [XLEN-1:0] ex_data,
  input  logic            wb_wen,
  input  logic [RA_W-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] src
);

  // x0 always reads zero; the younger EX result beats WB; a load in EX has no data yet
  always_comb begin
    src = rf_data;
    if (rs == REG_ZERO) begin
      src = '0;
    end else if (ex_wen && !ex_is_load && (ex_rd == rs)) begin
      src = ex_data;
    end else if (wb_wen && (wb_rd == rs)) begin
      src = wb_data;
    end
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// rtl/operand_fetch_stage.sv - operand fetch, forwarding, load-use detect and ID/EX register
module operand_fetch_stage
  import rv_pipe_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [RA_W-1:0]   in_rs1,
  input  logic [RA_W-1:0]   in_rs2,
  input  logic [RA_W-1:0]   in_rd,
  input  logic              in_use_rs1,
  input  logic              in_use_rs2,
  input  logic              in_use_imm,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic [RA_W-1:0]   rf_raddr1,
  output logic [RA_W-1:0]   rf_raddr2,
  input  logic [XLEN-1:0]   rf_rdata1,
  input  logic [XLEN-1:0]   rf_rdata2,
  input  logic              ex_wen,
  input  logic [RA_W-1:0]   ex_rd,
  input  logic [XLEN-1:0]   ex_data,
  input  logic              ex_is_load,
  input  logic              wb_wen,
  input  logic [RA_W-1:0]   wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_op1,
  output logic [XLEN-1:0]   out_op2,
  output logic [XLEN-1:0]   out_store_data,
  output logic [RA_W-1:0]   out_rd,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [31:0]       stall_count
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t          state;
  ctrl_t           ctrl_q;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic            luh;
  logic            take;

  assign rf_raddr1 = in_rs1;
  assign rf_raddr2 = in_rs2;

  fwd_mux u_fwd1 (
    .rs         (in_rs1),
    .rf_data    (rf_rdata1),
    .ex_wen     (ex_wen),
    .ex_is_load (ex_is_load),
    .ex_rd      (ex_rd),
    .ex_data    (ex_data),
    .wb_wen     (wb_wen),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .src        (src1)
  );

  fwd_mux u_fwd2 (
    .rs         (in_rs2),
    .rf_data    (rf_rdata2),
    .ex_wen     (ex_wen),
    .ex_is_load (ex_is_load),
    .ex_rd      (ex_rd),
    .ex_data    (ex_data),
    .wb_wen     (wb_wen),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .src        (src2)
  );

  // A load still in EX cannot forward, so a dependent instruction must wait one cycle
  always_comb begin
    luh = in_valid && ex_wen && ex_is_load && (ex_rd != REG_ZERO) &&
          ((in_use_rs1 && (ex_rd == in_rs1)) || (in_use_rs2 && (ex_rd == in_rs2)));
  end

  assign out_valid = (state == FULL);
  assign in_ready  = !luh && (!out_valid || out_ready);
  assign take      = in_valid && in_ready && !flush;
  assign out_ctrl  = ctrl_q;

  // ID/EX register: flush wins, payload only moves on capture so it is stable while held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= EMPTY;
      out_op1        <= '0;
      out_op2        <= '0;
      out_store_data <= '0;
      out_rd         <= '0;
      ctrl_q         <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: if (take) state <= FULL;
        FULL:  if (out_ready && !take) state <= EMPTY;
        default: state <= EMPTY;
      endcase
      if (take) begin
        out_op1        <= src1;
        out_op2        <= in_use_imm ? in_imm : src2;
        out_store_data <= src2;
        out_rd         <= in_rd;
        ctrl_q         <= ctrl_t'(in_ctrl);
      end
    end
  end

  // Saturating count of cycles lost to load-use hazards
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if (luh && (stall_count != 32'hFFFF_FFFF)) begin
      stall_count <= stall_count + 32'd1;
    end
  end

endmodule
